// File: rtl/register_file_if.sv
// Bus bundle between the operand/write-back logic and the register file:
// one write port plus two combinational read ports.
interface register_file_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
);
    // The write port has no handshake: rdWriteEnable is a plain strobe. When it
    // is high, rdNum/rdData are taken on the rising clk edge. The read ports
    // have no handshake either: data follows the addresses combinationally.
    logic [ADDR_W-1:0] rsNum;
    logic [ADDR_W-1:0] rtNum;
    logic [ADDR_W-1:0] rdNum;
    logic [WIDTH-1:0]  rdData;
    logic              rdWriteEnable;
    logic [WIDTH-1:0]  rsData;
    logic [WIDTH-1:0]  rtData;

    modport master (
        output rsNum, rtNum, rdNum, rdData, rdWriteEnable,
        input  rsData, rtData
    );

    modport slave (
        input  rsNum, rtNum, rdNum, rdData, rdWriteEnable,
        output rsData, rtData
    );
endinterface

// File: rtl/register_file.sv
// Architectural register file: NREGS enabled registers behind one write port
// and two combinational read ports. Entry 0 always reads as zero.
module register_file #(
    parameter int WIDTH  = 32,
    parameter int NREGS  = 32,
    parameter int ADDR_W = 5,
    parameter int BYPASS = 0
) (
    input logic            clk,
    input logic            reset,
    register_file_if.slave bus
);

    logic [WIDTH-1:0] regs [NREGS];
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic             rs_fwd;
    logic             rt_fwd;

    for (genvar i = 0; i < NREGS; i++) begin : g_entry
        if (i == 0) begin : g_zero
            assign regs[i] = '0;
        end else begin : g_reg
            logic             wr_en;
            logic [WIDTH-1:0] q;

            // One-hot decode: each entry compares the write address against its own index.
            assign wr_en = bus.rdWriteEnable && (bus.rdNum == ADDR_W'(i));

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    q <= '0;
                end else if (wr_en) begin
                    q <= bus.rdData;
                end
            end

            assign regs[i] = q;
        end
    end

    // Forwarding is suppressed for address 0 and while reset holds the array clear.
    always_comb begin
        rs_fwd = 1'b0;
        rt_fwd = 1'b0;
        if (BYPASS != 0) begin
            rs_fwd = reset && bus.rdWriteEnable && (bus.rsNum == bus.rdNum) && (bus.rsNum != '0);
            rt_fwd = reset && bus.rdWriteEnable && (bus.rtNum == bus.rdNum) && (bus.rtNum != '0);
        end
    end

    always_comb begin
        rs_val = regs[bus.rsNum];
        rt_val = regs[bus.rtNum];
        if (rs_fwd) rs_val = bus.rdData;
        if (rt_fwd) rt_val = bus.rdData;
    end

    assign bus.rsData = rs_val;
    assign bus.rtData = rt_val;

endmodule
